// File: rtl/drv_seq_pkg.sv
// Shared constants and state type for the LED driver shift sequencer.
// One slice is NB_PLANES bit-planes of BITS_PER_PLANE bits, shifted MSB-first.
package drv_seq_pkg;

  localparam int NB_DRIVERS     = 15;
  localparam int BITS_PER_PLANE = 48;
  localparam int NB_PLANES      = 9;
  localparam int SLICE_W        = BITS_PER_PLANE * NB_PLANES;
  localparam int WRTGS_LAT      = 1;
  localparam int LATGS_LAT      = 3;

  localparam int BIT_CNT_W   = 6;
  localparam int PLANE_CNT_W = 4;

  localparam logic [BIT_CNT_W-1:0]   BIT_LAST   = BIT_CNT_W'(BITS_PER_PLANE - 1);
  localparam logic [PLANE_CNT_W-1:0] PLANE_LAST = PLANE_CNT_W'(NB_PLANES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } seq_state_t;

endpackage

// File: rtl/drv_lat_gen.sv
// Driver LAT generation: short WRTGS pulse closing planes 8..1, longer LATGS
// pulse closing plane 0, only while the slice is actually shifting.
module drv_lat_gen
  import drv_seq_pkg::*;
(
  input  logic [BIT_CNT_W-1:0]   i_bit_cnt,
  input  logic [PLANE_CNT_W-1:0] i_plane_cnt,
  input  logic                   i_in_shift,
  output logic                   o_drv_lat
);

  logic [BIT_CNT_W-1:0] w_lat_len;

  assign w_lat_len = (i_plane_cnt == '0) ? BIT_CNT_W'(LATGS_LAT) : BIT_CNT_W'(WRTGS_LAT);
  assign o_drv_lat = i_in_shift && (i_bit_cnt < w_lat_len);

endmodule

// File: rtl/driver_shift_sequencer.sv
// Captures one 15x432-bit slice and shifts it MSB-first onto 15 SIN lines,
// with gated SCLK enable, driver LAT timing and an end-of-slice pulse.
//
// state | meaning
// IDLE  | waiting for a slice, data_ready high
// SHIFT | 432 cycles of serial data, counters walk plane 8..0 / bit 47..0
// GAP   | one quiet cycle, frame_done pulse
module driver_shift_sequencer
  import drv_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [SLICE_W-1:0]    data_in [NB_DRIVERS-1:0],
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  flush,
  output logic [NB_DRIVERS-1:0] drv_sin,
  output logic                  drv_sclk_en,
  output logic                  drv_lat,
  output logic                  busy,
  output logic                  frame_done
);

  seq_state_t               r_state;
  seq_state_t               w_state_nxt;
  logic [BIT_CNT_W-1:0]     r_bit_cnt;
  logic [PLANE_CNT_W-1:0]   r_plane_cnt;
  logic [SLICE_W-1:0]       r_buf [NB_DRIVERS-1:0];
  logic                     w_xfer;
  logic                     w_in_shift;
  logic                     w_last_bit;

  assign data_ready  = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign w_xfer      = data_valid && data_ready && !flush;
  assign w_in_shift  = (r_state == SHIFT) && !flush;
  assign w_last_bit  = (r_bit_cnt == '0) && (r_plane_cnt == '0);
  assign drv_sclk_en = w_in_shift;
  assign frame_done  = (r_state == GAP) && !flush;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_xfer) w_state_nxt = SHIFT;
      SHIFT: begin
        if (flush)           w_state_nxt = IDLE;
        else if (w_last_bit) w_state_nxt = GAP;
      end
      GAP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_bit_cnt   <= '0;
      r_plane_cnt <= '0;
    end else if (w_xfer) begin
      r_bit_cnt   <= BIT_LAST;
      r_plane_cnt <= PLANE_LAST;
    end else if (w_in_shift) begin
      if (r_bit_cnt == '0) begin
        if (!w_last_bit) begin
          r_bit_cnt   <= BIT_LAST;
          r_plane_cnt <= r_plane_cnt - 1'b1;
        end
      end else begin
        r_bit_cnt <= r_bit_cnt - 1'b1;
      end
    end else begin
      r_bit_cnt   <= '0;
      r_plane_cnt <= '0;
    end
  end

  // The buffer itself shifts left, so its MSB is always the bit addressed by
  // 48*plane_cnt + bit_cnt and no wide read mux is needed.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int d = 0; d < NB_DRIVERS; d++) r_buf[d] <= '0;
    end else if (w_xfer) begin
      for (int d = 0; d < NB_DRIVERS; d++) r_buf[d] <= data_in[d];
    end else if (w_in_shift) begin
      for (int d = 0; d < NB_DRIVERS; d++) r_buf[d] <= {r_buf[d][SLICE_W-2:0], 1'b0};
    end
  end

  always_comb begin
    drv_sin = '0;
    for (int d = 0; d < NB_DRIVERS; d++) drv_sin[d] = w_in_shift & r_buf[d][SLICE_W-1];
  end

  drv_lat_gen u_lat_gen (
    .i_bit_cnt   (r_bit_cnt),
    .i_plane_cnt (r_plane_cnt),
    .i_in_shift  (w_in_shift),
    .o_drv_lat   (drv_lat)
  );

endmodule

// File: tb/tb_driver_shift_sequencer.sv
// Directed bench for driver_shift_sequencer: per-cycle scoreboard of the
// expected pin state built from a bit-index model of each slice.
module tb_driver_shift_sequencer;
  import drv_seq_pkg::*;

  logic                  clk = 1'b0;
  logic                  nrst = 1'b0;
  logic [SLICE_W-1:0]    data_in [NB_DRIVERS-1:0];
  logic                  data_valid = 1'b0;
  logic                  flush = 1'b0;
  logic                  data_ready;
  logic [NB_DRIVERS-1:0] drv_sin;
  logic                  drv_sclk_en;
  logic                  drv_lat;
  logic                  busy;
  logic                  frame_done;

  typedef struct packed {
    logic        ready;
    logic        busy;
    logic        done;
    logic        lat;
    logic        sclk;
    logic [14:0] sin;
  } obs_t;

  obs_t               exp_q[$];
  logic [SLICE_W-1:0] slice [NB_DRIVERS];
  int                 checks = 0;
  int                 failures = 0;
  int                 lat_cnt;
  int                 sclk_cnt;
  int                 done_cnt;

  always #5 clk = ~clk;

  driver_shift_sequencer dut (
    .clk         (clk),
    .nrst        (nrst),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .flush       (flush),
    .drv_sin     (drv_sin),
    .drv_sclk_en (drv_sclk_en),
    .drv_lat     (drv_lat),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  function automatic obs_t sample();
    obs_t o;
    o.ready = data_ready;
    o.busy  = busy;
    o.done  = frame_done;
    o.lat   = drv_lat;
    o.sclk  = drv_sclk_en;
    o.sin   = drv_sin;
    return o;
  endfunction

  function automatic obs_t idle_exp();
    obs_t e = '0;
    e.ready = 1'b1;
    return e;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected pins for SHIFT cycles 1..432 and the GAP cycle of the current slice.
  task automatic push_slice();
    obs_t e;
    int idx, p, b;
    for (int k = 1; k <= 432; k++) begin
      idx    = 432 - k;
      p      = idx / 48;
      b      = idx % 48;
      e      = '0;
      e.busy = 1'b1;
      e.sclk = 1'b1;
      for (int d = 0; d < 15; d++) e.sin[d] = slice[d][idx];
      e.lat  = (p == 0) ? (b < 3) : (b < 1);
      exp_q.push_back(e);
    end
    e      = '0;
    e.busy = 1'b1;
    e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic run_check(string tag, int n);
    obs_t o, e;
    for (int i = 0; i < n; i++) begin
      o = sample();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check($sformatf("%s_cyc%0d", tag, i + 1), 32'(o), 32'(e));
      lat_cnt  += int'(o.lat);
      sclk_cnt += int'(o.sclk);
      tick();
    end
  endtask

  task automatic send_slice(string tag);
    for (int d = 0; d < NB_DRIVERS; d++) data_in[d] = slice[d];
    data_valid = 1'b1;
    check($sformatf("%s_pre", tag), 32'(sample()), 32'(idle_exp()));
    tick();
    data_valid = 1'b0;
    push_slice();
    run_check(tag, 433);
    check($sformatf("%s_post", tag), 32'(sample()), 32'(idle_exp()));
  endtask

  task automatic random_slice();
    for (int d = 0; d < NB_DRIVERS; d++)
      for (int b = 0; b < SLICE_W; b++) slice[d][b] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    for (int d = 0; d < NB_DRIVERS; d++) data_in[d] = '0;

    // reset and quiet idle
    repeat (3) tick();
    check("in_reset", 32'(sample()), 32'(idle_exp()));
    nrst = 1'b1;
    tick();
    for (int i = 0; i < 1000; i++) begin
      check("idle", 32'(sample()), 32'(idle_exp()));
      tick();
    end

    // diagonal one-hot slice
    for (int d = 0; d < NB_DRIVERS; d++) slice[d] = SLICE_W'(1) << (SLICE_W - 1 - d);
    send_slice("onehot");

    // all-ones slice: SCLK and LAT totals
    for (int d = 0; d < NB_DRIVERS; d++) slice[d] = '1;
    lat_cnt  = 0;
    sclk_cnt = 0;
    send_slice("ones");
    check("sclk_cycles", 32'(sclk_cnt), 32'd432);
    check("lat_cycles", 32'(lat_cnt), 32'd11);

    // back-to-back with data_valid held; data_in changes while busy
    random_slice();
    for (int d = 0; d < NB_DRIVERS; d++) data_in[d] = slice[d];
    data_valid = 1'b1;
    check("b2b_pre", 32'(sample()), 32'(idle_exp()));
    for (int s = 0; s < 3; s++) begin
      tick();
      push_slice();
      random_slice();
      for (int d = 0; d < NB_DRIVERS; d++) data_in[d] = slice[d];
      run_check($sformatf("b2b%0d", s), 433);
      check($sformatf("b2b%0d_idle", s), 32'(sample()), 32'(idle_exp()));
      if (s == 2) data_valid = 1'b0;
    end
    tick();
    check("b2b_stop", 32'(sample()), 32'(idle_exp()));

    // flush at SHIFT cycle 100
    random_slice();
    for (int d = 0; d < NB_DRIVERS; d++) data_in[d] = slice[d];
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    push_slice();
    run_check("pre_flush", 100);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    check("flush_next", 32'(sample()), 32'(idle_exp()));
    done_cnt = 0;
    for (int i = 0; i < 500; i++) begin
      done_cnt += int'(frame_done);
      tick();
    end
    check("flush_no_done", 32'(done_cnt), 32'd0);
    random_slice();
    send_slice("after_flush");

    // flush together with data_valid in IDLE: nothing captured
    data_valid = 1'b1;
    flush      = 1'b1;
    tick();
    data_valid = 1'b0;
    flush      = 1'b0;
    check("flush_idle", 32'(sample()), 32'(idle_exp()));
    tick();
    check("flush_idle2", 32'(sample()), 32'(idle_exp()));

    // asynchronous reset at SHIFT cycle 200
    for (int d = 0; d < NB_DRIVERS; d++) slice[d] = '1;
    for (int d = 0; d < NB_DRIVERS; d++) data_in[d] = slice[d];
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    push_slice();
    run_check("pre_rst", 200);
    nrst = 1'b0;
    #1;
    check("rst_async", 32'(sample()), 32'(idle_exp()));
    exp_q.delete();
    tick();
    nrst = 1'b1;
    tick();
    check("rst_release", 32'(sample()), 32'(idle_exp()));
    random_slice();
    send_slice("after_rst");

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
